// File: rtl/life_if.sv
// Control and status bundle between the button/control logic and life_engine.
// The engine takes the slave side; the controller and display take the master side.
interface life_if #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = $clog2(ROWS * COLS + 1);

  logic                 run;
  logic                 step;
  logic                 clear;
  logic                 load_en;
  logic [RW-1:0]        load_row;
  logic [COLS-1:0]      load_data;
  logic [ROWS*COLS-1:0] cells;
  logic                 busy;
  logic                 gen_done;
  logic [GEN_W-1:0]     generation;
  logic [PW-1:0]        population;
  logic                 stable;

  modport master (
    output run, step, clear, load_en, load_row, load_data,
    input  cells, busy, gen_done, generation, population, stable
  );

  modport slave (
    input  run, step, clear, load_en, load_row, load_data,
    output cells, busy, gen_done, generation, population, stable
  );
endinterface

// File: rtl/life_engine.sv
// Row-serial cellular-automaton engine: evaluates one board row per cycle into a shadow
// board, then commits the whole generation at once together with its status.
module life_engine #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned WRAP    = 0,
  parameter logic [8:0]  BIRTH   = 9'b000001000,
  parameter logic [8:0]  SURVIVE = 9'b000001100,
  parameter int unsigned GEN_W   = 16,
  parameter int unsigned DIVIDER = 1
) (
  input logic   clk,
  input logic   rst_n,
  life_if.slave bus
);

  localparam int unsigned BW = ROWS * COLS;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = $clog2(ROWS * COLS + 1);
  localparam int unsigned TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int          NR = ROWS;
  localparam int          NC = COLS;

  typedef enum logic [1:0] {StIdle, StEval, StCommit} state_e;

  state_e           state_q;
  logic [BW-1:0]    cells_q, shadow_q;
  logic [RW-1:0]    row_q;
  logic [TW-1:0]    tick_q;
  logic [PW-1:0]    pop_acc_q, population_q;
  logic [GEN_W-1:0] gen_q;
  logic             mism_q, stable_q, busy_q, gen_done_q;

  logic [COLS-1:0]  cur_row, nxt_row;
  logic [3:0]       nbr;
  logic [PW-1:0]    row_pop;
  logic [BW-1:0]    shadow_ins, cells_loaded;
  logic             trigger;

  // Off-board neighbours read as dead unless the board is toroidal.
  function automatic logic cell_at(input logic [BW-1:0] b, input int r, input int c);
    int            rr, cc;
    logic [BW-1:0] sh;
    rr = r;
    cc = c;
    if (WRAP != 0) begin
      rr = (r + NR) % NR;
      cc = (c + NC) % NC;
    end else if (r < 0 || r >= NR || c < 0 || c >= NC) begin
      return 1'b0;
    end
    sh = b >> (rr * NC + cc);
    return sh[0];
  endfunction

  always_comb begin
    cur_row = COLS'(cells_q >> (int'(row_q) * NC));
    nxt_row = '0;
    row_pop = '0;
    nbr     = '0;
    for (int c = 0; c < NC; c++) begin
      nbr = '0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) begin
            nbr = nbr + 4'(cell_at(cells_q, int'(row_q) + dr, c + dc));
          end
        end
      end
      nxt_row[c] = cur_row[c] ? SURVIVE[nbr] : BIRTH[nbr];
      row_pop    = row_pop + PW'(nxt_row[c]);
    end
    shadow_ins   = (shadow_q & ~(BW'({COLS{1'b1}}) << (int'(row_q) * NC)))
                 | (BW'(nxt_row) << (int'(row_q) * NC));
    cells_loaded = (cells_q & ~(BW'({COLS{1'b1}}) << (int'(bus.load_row) * NC)))
                 | (BW'(bus.load_data) << (int'(bus.load_row) * NC));
    trigger      = bus.step | (bus.run & (tick_q == TW'(DIVIDER - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cells_q      <= '0;
      shadow_q     <= '0;
      row_q        <= '0;
      tick_q       <= '0;
      pop_acc_q    <= '0;
      population_q <= '0;
      gen_q        <= '0;
      mism_q       <= 1'b0;
      stable_q     <= 1'b1;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          gen_done_q <= 1'b0;
          if (bus.clear) begin
            cells_q      <= '0;
            gen_q        <= '0;
            population_q <= '0;
            stable_q     <= 1'b1;
            tick_q       <= '0;
          end else if (bus.load_en) begin
            cells_q <= cells_loaded;
          end else if (trigger) begin
            state_q   <= StEval;
            busy_q    <= 1'b1;
            row_q     <= '0;
            pop_acc_q <= '0;
            mism_q    <= 1'b0;
            tick_q    <= '0;
          end else if (bus.run) begin
            tick_q <= tick_q + TW'(1);
          end
        end
        StEval: begin
          shadow_q  <= shadow_ins;
          pop_acc_q <= pop_acc_q + row_pop;
          mism_q    <= mism_q | (nxt_row != cur_row);
          if (row_q == RW'(ROWS - 1)) begin
            state_q <= StCommit;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        StCommit: begin
          cells_q      <= shadow_q;
          gen_q        <= gen_q + GEN_W'(1);
          population_q <= pop_acc_q;
          stable_q     <= ~mism_q;
          gen_done_q   <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cells      = cells_q;
  assign bus.busy       = busy_q;
  assign bus.gen_done   = gen_done_q;
  assign bus.generation = gen_q;
  assign bus.population = population_q;
  assign bus.stable     = stable_q;

endmodule

// File: tb/tb_life_engine.sv
// Drives a dead-edge (u_a) and a toroidal (u_b) engine with shared stimulus and checks
// each committed generation against an independent 8x8 Life model via a scoreboard.
module tb_life_engine;

  typedef struct {
    logic [63:0] board;
    int          pop;
    bit          stable;
    int          gen;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run, step, clear, load_en;
  logic [2:0] load_row;
  logic [7:0] load_data;

  int          n_pass = 0, n_total = 0, n_fail = 0;
  exp_t        qa[$], qb[$];
  logic [63:0] mdl_a = '0, mdl_b = '0;
  int          gen_a = 0, gen_b = 0;

  life_if #(.ROWS(8), .COLS(8), .GEN_W(2))  ifa ();
  life_if #(.ROWS(8), .COLS(8), .GEN_W(16)) ifb ();

  assign ifa.run = run;           assign ifb.run = run;
  assign ifa.step = step;         assign ifb.step = step;
  assign ifa.clear = clear;       assign ifb.clear = clear;
  assign ifa.load_en = load_en;   assign ifb.load_en = load_en;
  assign ifa.load_row = load_row; assign ifb.load_row = load_row;
  assign ifa.load_data = load_data;
  assign ifb.load_data = load_data;

  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(2), .DIVIDER(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16), .DIVIDER(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Conway B3/S23 reference on an 8x8 board.
  function automatic logic [63:0] life_ref(input logic [63:0] b, input bit wrap);
    logic [63:0] nx;
    int n, rr, cc;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) n += int'(b[rr*8+cc]);
          end
        end
        nx[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic push_expected();
    exp_t e;
    logic [63:0] nb;
    nb = life_ref(mdl_a, 1'b0);
    gen_a++;
    e.board = nb; e.pop = $countones(nb); e.stable = (nb == mdl_a); e.gen = gen_a;
    qa.push_back(e);
    mdl_a = nb;
    nb = life_ref(mdl_b, 1'b1);
    gen_b++;
    e.board = nb; e.pop = $countones(nb); e.stable = (nb == mdl_b); e.gen = gen_b;
    qb.push_back(e);
    mdl_b = nb;
  endtask

  task automatic compare_sb();
    exp_t e;
    e = qa.pop_front();
    chk("a_cells", ifa.cells, e.board);
    chk("a_population", 64'(ifa.population), 64'(e.pop));
    chk("a_stable", 64'(ifa.stable), 64'(e.stable));
    chk("a_generation", 64'(ifa.generation), 64'(e.gen % 4));
    e = qb.pop_front();
    chk("b_cells", ifb.cells, e.board);
    chk("b_population", 64'(ifb.population), 64'(e.pop));
    chk("b_stable", 64'(ifb.stable), 64'(e.stable));
    chk("b_generation", 64'(ifb.generation), 64'(e.gen % 65536));
  endtask

  // One step; with inject, clear/load/step are pulsed while the engine is busy.
  task automatic do_step(input bit inject);
    int lat, nbusy;
    push_expected();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    lat = 1;
    nbusy = int'(ifa.busy);
    while (!ifa.gen_done && lat < 40) begin
      if (inject && lat == 3) begin
        clear = 1'b1; load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; step = 1'b1;
      end else begin
        clear = 1'b0; load_en = 1'b0; step = 1'b0;
      end
      @(negedge clk);
      lat++;
      nbusy += int'(ifa.busy);
    end
    clear = 1'b0; load_en = 1'b0; step = 1'b0;
    chk("latency", 64'(lat), 64'd10);
    chk("busy_cycles", 64'(nbusy), 64'd9);
    chk("b_gen_done", 64'(ifb.gen_done), 64'd1);
    compare_sb();
    @(negedge clk);
    chk("gen_done_fall", 64'(ifa.gen_done), 64'd0);
    chk("idle_after", 64'(ifa.busy), 64'd0);
  endtask

  task automatic do_load(input logic [2:0] r, input logic [7:0] d);
    load_en = 1'b1; load_row = r; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mdl_a[r*8 +: 8] = d;
    mdl_b[r*8 +: 8] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mdl_a = '0; mdl_b = '0; gen_a = 0; gen_b = 0;
    chk("clr_cells", ifa.cells, 64'd0);
    chk("clr_generation", 64'(ifa.generation), 64'd0);
    chk("clr_population", 64'(ifa.population), 64'd0);
    chk("clr_stable", 64'(ifa.stable), 64'd1);
  endtask

  initial begin
    int ta[$], tb[$];
    int na, nb;
    run = 1'b0; step = 1'b0; clear = 1'b0; load_en = 1'b0;
    load_row = '0; load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cells", ifa.cells, 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_gen_done", 64'(ifa.gen_done), 64'd0);
    chk("rst_generation", 64'(ifa.generation), 64'd0);
    chk("rst_population", 64'(ifa.population), 64'd0);
    chk("rst_stable", 64'(ifa.stable), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Blinker: vertical after one step, horizontal after two.
    do_load(3'd3, 8'b00011100);
    chk("load_visible", 64'(ifa.cells[31:24]), 64'h1C);
    do_step(1'b0);
    chk("blinker_vertical", ifa.cells, 64'h0000_0008_0808_0000);
    chk("blinker_pop", 64'(ifa.population), 64'd3);
    do_step(1'b0);
    chk("blinker_restored", 64'(ifa.cells[31:24]), 64'h1C);
    chk("blinker_gen2", 64'(ifa.generation), 64'd2);

    // Commands during busy are dropped; a 2-bit generation wraps 3 -> 0.
    do_step(1'b1);
    @(negedge clk);
    chk("no_queued_step", 64'(ifa.busy), 64'd0);
    do_step(1'b0);
    chk("gen_wrap", 64'(ifa.generation), 64'd0);
    do_clear();

    // Block still life.
    do_load(3'd3, 8'b00011000);
    do_load(3'd4, 8'b00011000);
    do_step(1'b0);
    chk("block_cells", ifa.cells, 64'h0000_0018_1800_0000);
    chk("block_stable", 64'(ifa.stable), 64'd1);
    do_clear();

    // Edge blinker on column 0.
    do_load(3'd3, 8'b00000001);
    do_load(3'd4, 8'b00000001);
    do_load(3'd5, 8'b00000001);
    do_step(1'b0);
    chk("dead_edge_row4", 64'(ifa.cells[39:32]), 64'h03);
    chk("dead_edge_pop", 64'(ifa.population), 64'd2);
    chk("wrap_row4", 64'(ifb.cells[39:32]), 64'h83);
    chk("wrap_pop", 64'(ifb.population), 64'd3);
    do_clear();

    // Free-run: period DIVIDER+ROWS+1 on each engine.
    do_load(3'd3, 8'b00011100);
    run = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (ifa.gen_done) ta.push_back(cyc);
      if (ifb.gen_done) tb.push_back(cyc);
    end
    run = 1'b0;
    chk("a_run_pulses", 64'(ta.size() >= 3), 64'd1);
    chk("b_run_pulses", 64'(tb.size() >= 3), 64'd1);
    while (ta.size() < 3) ta.push_back(0);
    while (tb.size() < 3) tb.push_back(0);
    chk("a_period1", 64'(ta[1] - ta[0]), 64'd13);
    chk("a_period2", 64'(ta[2] - ta[1]), 64'd13);
    chk("b_period1", 64'(tb[1] - tb[0]), 64'd10);
    chk("b_period2", 64'(tb[2] - tb[1]), 64'd10);
    na = 0;
    nb = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      na += int'(ifa.gen_done);
      nb += int'(ifb.gen_done);
    end
    chk("a_run_stop", 64'(na <= 1), 64'd1);
    chk("b_run_stop", 64'(nb <= 1), 64'd1);
    chk("run_stop_idle", 64'(ifa.busy | ifb.busy), 64'd0);
    do_clear();

    // Reset while row 4 is being evaluated abandons the generation.
    do_load(3'd3, 8'b00011100);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 64'(ifa.busy), 64'd1);
    chk("pre_reset_cells", ifa.cells, 64'h0000_0000_1C00_0000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cells", ifa.cells, 64'd0);
    chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
    chk("mid_rst_gen_done", 64'(ifa.gen_done), 64'd0);
    chk("mid_rst_generation", 64'(ifb.generation), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_a = '0; mdl_b = '0; gen_a = 0; gen_b = 0;
    @(negedge clk);
    do_step(1'b0);
    chk("empty_pop", 64'(ifa.population), 64'd0);
    chk("empty_stable", 64'(ifa.stable), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/life_engine.md
# life_engine

- Parametrised, row-serial cellular-automaton engine; successor to the fixed 8×8 Game of Life core.
- Adds:
  - rectangular ROWS×COLS boards;
  - selectable dead-edge or toroidal boundary;
  - programmable birth/survive rules;
  - row loading and clear;
  - single-step and divided free-run modes;
  - generation, population and still-life status.
- Sits between the button/control logic and the LED-array display driver, which consumes `cells`.

## Interface
Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns.
- WRAP, 0, boundary mode: 0 = off-board neighbours are dead; 1 = toroidal.
- BIRTH, 9'b000001000, bit k set: a dead cell with k live neighbours is born.
- SURVIVE, 9'b000001100, bit k set: a live cell with k live neighbours stays live.
- GEN_W, 16, generation counter width.
- DIVIDER, 1, IDLE cycles per automatic step in run mode (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- run  in  1  level; free-running stepping.
- step  in  1  request one generation.
- clear  in  1  zero the board.
- load_en  in  1  write one board row.
- load_row  in  $clog2(ROWS)  row index to write.
- load_data  in  COLS  row contents; bit c = column c.
- cells  out  ROWS*COLS  registered board; cell (r,c) = bit r*COLS+c.
- busy  out  1  high whenever the state is not IDLE.
- gen_done  out  1  one-cycle pulse per committed generation.
- generation  out  GEN_W  committed generation count.
- population  out  $clog2(ROWS*COLS+1)  live cells in the last committed generation.
- stable  out  1  last committed generation equalled its predecessor.

## Operation
- FSM states: IDLE, EVAL, COMMIT.
- IDLE command priority: clear > load_en > (step | run trigger).
  - clear: cells=0, generation=0, population=0, stable=1, tick=0.
  - load_en: cells row load_row ← load_data. Other rows are unchanged. generation, population and stable are not changed.
  - Trigger: step=1, or run=1 with tick==DIVIDER-1. Both together produce a single trigger. Go to EVAL with row=0, accumulators cleared, tick=0.
- Outside IDLE, clear, load_en and step are ignored (not queued).
- Tick counter:
  - increments only in IDLE with run=1 and no trigger;
  - holds when run=0;
  - cleared on trigger.
- EVAL:
  - One row per cycle, row 0 to ROWS-1.
  - Each row's next state is computed from the unchanged current board into a shadow register.
  - Per cell: 4-bit neighbour count n (0..8). next = cur ? SURVIVE[n] : BIRTH[n].
  - WRAP=1: row and column indices are taken modulo ROWS/COLS.
  - Popcount and a mismatch flag are accumulated across rows.
  - After row ROWS-1, go to COMMIT.
- COMMIT:
  - cells ← shadow.
  - generation +1, wrapping 2^GEN_W-1 → 0.
  - population ← accumulated count.
  - stable ← no mismatch.
  - gen_done=1; go to IDLE.
- Reset values:
  - cells=0, generation=0, population=0, stable=1.
  - busy=0, gen_done=0, state=IDLE, tick=0.
- Reset asserted mid-EVAL/COMMIT abandons the generation; the shadow contents are discarded.

## Timing
- The edge sampling a trigger in IDLE is E0.
  - Rows are evaluated at edges E1..E_ROWS.
  - Commit happens at E_ROWS+1.
- cells, generation, population, stable and gen_done change together, ROWS+1 cycles after E0.
- busy is high for exactly ROWS+1 cycles per generation.
- gen_done is high for exactly one cycle and falls on the next edge.
- Run-mode gen_done period = DIVIDER+ROWS+1 cycles (ROWS=8, DIVIDER=1: 10 cycles).
- load_en and clear take effect at the sampling edge and are visible the next cycle.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Blinker, 8×8, WRAP=0:
  - Stimulus: load row 3 = 8'b00011100, then step.
  - Required after 9 cycles: column 3 set in rows 2,3,4 only; generation=1; population=3; stable=0; one gen_done pulse.
  - Step again: row 3 = 8'b00011100 restored; generation=2.
- Block still life:
  - Stimulus: rows 3,4 = 8'b00011000, then step.
  - Required: cells unchanged; population=4; stable=1.
- Boundary mode:
  - Stimulus: column 0 set in rows 3-5, then step.
  - WRAP=1: row 4 = 8'b10000011, population=3.
  - WRAP=0: row 4 = 8'b00000011, population=2.
- Run mode, DIVIDER=4, ROWS=8:
  - Stimulus: hold run.
  - Required: gen_done pulses exactly 13 cycles apart.
  - Dropping run: pulses stop once any in-flight generation commits.
- Ignored commands and counter wrap:
  - Stimulus: clear, load_en and step during busy.
  - Required: no effect.
  - Stimulus: GEN_W=2, 4 steps.
  - Required: generation 1,2,3,0.
  - Stimulus: clear in IDLE.
  - Required: cells=0, generation=0, stable=1.
- Reset mid-operation:
  - Stimulus: deassert rst_n in EVAL at row 4.
  - Required: immediately cells=0, busy=0, gen_done=0, generation=0. The next step from an empty board yields population=0, stable=1.
